// File: rtl/axi_wr_arbiter.sv
// Round-robin AW/W/B ownership arbiter for one AXI slave port.
// Holds a grant from AW acceptance through the B response, with a RESP watchdog.
module axi_wr_arbiter #(
    parameter int NumMasters    = 4,
    parameter int GrantWidth    = (NumMasters > 1) ? $clog2(NumMasters) : 1,
    parameter int TimeoutCycles = 1024
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic [NumMasters-1:0] aw_req_i,
    input  logic                  aw_hs_i,
    input  logic                  w_last_hs_i,
    input  logic                  b_hs_i,
    output logic [GrantWidth-1:0] grant_o,
    output logic [NumMasters-1:0] aw_grant_o,
    output logic                  w_en_o,
    output logic                  b_en_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

    localparam logic [GrantWidth:0]   NumM     = (GrantWidth+1)'(NumMasters);
    localparam logic [GrantWidth-1:0] LastIdx  = GrantWidth'(NumMasters - 1);
    localparam logic [15:0]           WdogLast = 16'(TimeoutCycles - 1);

    state_e                  state;
    logic [GrantWidth-1:0]   ptr;
    logic                    wdone;
    logic [15:0]             wdog;
    logic [GrantWidth-1:0]   sel;
    logic [GrantWidth:0]     cand;
    logic                    found;
    logic                    wdog_hit;

    // First requester at or above ptr, wrapping past the last master.
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NumMasters; i++) begin
            cand = {1'b0, ptr} + (GrantWidth+1)'(i);
            if (cand >= NumM) cand = cand - NumM;
            if (!found && aw_req_i[cand[GrantWidth-1:0]]) begin
                sel   = cand[GrantWidth-1:0];
                found = 1'b1;
            end
        end
    end

    assign wdog_hit = (wdog == WdogLast);

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            grant_o    <= '0;
            aw_grant_o <= '0;
            w_en_o     <= 1'b0;
            b_en_o     <= 1'b0;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b0;
            wdone      <= 1'b0;
            wdog       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|aw_req_i) begin
                        state      <= ADDR;
                        grant_o    <= sel;
                        aw_grant_o <= NumMasters'(1) << sel;
                        w_en_o     <= 1'b1;
                        busy_o     <= 1'b1;
                    end
                end
                ADDR: begin
                    if (aw_hs_i) begin
                        aw_grant_o <= '0;
                        if (w_last_hs_i || wdone) begin
                            state  <= RESP;
                            w_en_o <= 1'b0;
                            b_en_o <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end else if (w_last_hs_i) begin
                        wdone <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_last_hs_i) begin
                        state  <= RESP;
                        w_en_o <= 1'b0;
                        b_en_o <= 1'b1;
                    end
                end
                RESP: begin
                    if (b_hs_i || wdog_hit) begin
                        state  <= IDLE;
                        b_en_o <= 1'b0;
                        busy_o <= 1'b0;
                        wdone  <= 1'b0;
                        wdog   <= '0;
                        ptr    <= (grant_o == LastIdx) ? '0 : grant_o + 1'b1;
                        if (wdog_hit) timeout_o <= 1'b1;
                    end else if (wdog != 16'hFFFF) begin
                        wdog <= wdog + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: per-cycle vector table plus
// hand sequences for watchdog timeout and asynchronous reset.
module tb_axi_wr_arbiter;

    logic       aclk = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] aw_req_i = '0;
    logic       aw_hs_i = 1'b0;
    logic       w_last_hs_i = 1'b0;
    logic       b_hs_i = 1'b0;
    logic [1:0] grant_o;
    logic [3:0] aw_grant_o;
    logic       w_en_o, b_en_o, busy_o, timeout_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] req;
        logic [2:0] hs;    // {aw, wlast, b}
        logic [1:0] g;
        logic [3:0] ag;
        logic [3:0] fl;    // {w_en, b_en, busy, timeout}
    } vec_t;

    vec_t vq[$];

    axi_wr_arbiter #(
        .NumMasters(4),
        .TimeoutCycles(8)
    ) dut (
        .aclk(aclk),
        .rst(rst),
        .aw_req_i(aw_req_i),
        .aw_hs_i(aw_hs_i),
        .w_last_hs_i(w_last_hs_i),
        .b_hs_i(b_hs_i),
        .grant_o(grant_o),
        .aw_grant_o(aw_grant_o),
        .w_en_o(w_en_o),
        .b_en_o(b_en_o),
        .busy_o(busy_o),
        .timeout_o(timeout_o)
    );

    always #5 aclk = ~aclk;

    function automatic logic [9:0] outs();
        return {grant_o, aw_grant_o, w_en_o, b_en_o, busy_o, timeout_o};
    endfunction

    task automatic chk(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = outs();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got g=%0d ag=%b wbBt=%b, want g=%0d ag=%b wbBt=%b",
                     name, got[9:8], got[7:4], got[3:0],
                     exp[9:8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [2:0] hs,
                       input logic [1:0] g, input logic [3:0] ag,
                       input logic [3:0] fl);
        vec_t v;
        v.req = r; v.hs = hs; v.g = g; v.ag = ag; v.fl = fl;
        vq.push_back(v);
    endtask

    // Minimum-latency transaction: AW, WLAST, B on consecutive cycles.
    task automatic txn(input logic [3:0] r, input logic [1:0] n);
        logic [3:0] one;
        one = 4'b0001;
        add(r, 3'b000, n, one << n, 4'b1010);
        add(r, 3'b100, n, 4'b0000, 4'b1010);
        add(r, 3'b010, n, 4'b0000, 4'b0110);
        add(r, 3'b001, n, 4'b0000, 4'b0000);
    endtask

    task automatic step(input logic [3:0] r, input logic [2:0] hs);
        @(negedge aclk);
        aw_req_i = r;
        {aw_hs_i, w_last_hs_i, b_hs_i} = hs;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("reset", 10'b0);
        @(negedge aclk);
        rst = 1'b0;

        add(4'b0000, 3'b111, 2'd0, 4'b0000, 4'b0000);
        txn(4'b1111, 2'd0);
        txn(4'b1111, 2'd1);
        txn(4'b1111, 2'd2);
        txn(4'b1111, 2'd3);
        txn(4'b1111, 2'd0);
        txn(4'b0100, 2'd2);
        txn(4'b0101, 2'd0);
        txn(4'b0101, 2'd2);
        // W before AW: second WLAST ignored, ADDR goes straight to RESP
        add(4'b0010, 3'b000, 2'd1, 4'b0010, 4'b1010);
        add(4'b0010, 3'b010, 2'd1, 4'b0010, 4'b1010);
        add(4'b0010, 3'b010, 2'd1, 4'b0010, 4'b1010);
        add(4'b0010, 3'b100, 2'd1, 4'b0000, 4'b0110);
        add(4'b0010, 3'b001, 2'd1, 4'b0000, 4'b0000);
        // Request drop in ADDR and stray handshakes
        add(4'b1000, 3'b000, 2'd3, 4'b1000, 4'b1010);
        add(4'b0000, 3'b000, 2'd3, 4'b1000, 4'b1010);
        add(4'b0000, 3'b001, 2'd3, 4'b1000, 4'b1010);
        add(4'b0001, 3'b000, 2'd3, 4'b1000, 4'b1010);
        add(4'b0001, 3'b100, 2'd3, 4'b0000, 4'b1010);
        add(4'b0001, 3'b001, 2'd3, 4'b0000, 4'b1010);
        add(4'b0001, 3'b010, 2'd3, 4'b0000, 4'b0110);
        add(4'b0001, 3'b100, 2'd3, 4'b0000, 4'b0110);
        add(4'b0001, 3'b001, 2'd3, 4'b0000, 4'b0000);
        txn(4'b0001, 2'd0);
        // AW and WLAST together
        add(4'b0010, 3'b000, 2'd1, 4'b0010, 4'b1010);
        add(4'b0010, 3'b110, 2'd1, 4'b0000, 4'b0110);
        add(4'b0010, 3'b001, 2'd1, 4'b0000, 4'b0000);

        foreach (vq[i]) begin
            step(vq[i].req, vq[i].hs);
            chk($sformatf("vec%0d", i), {vq[i].g, vq[i].ag, vq[i].fl});
        end

        // Watchdog: 8 RESP cycles without B
        step(4'b0100, 3'b000);
        chk("to_addr", {2'd2, 4'b0100, 4'b1010});
        step(4'b0000, 3'b110);
        chk("to_resp", {2'd2, 4'b0000, 4'b0110});
        for (int k = 1; k < 8; k++) begin
            step(4'b0000, 3'b000);
            chk($sformatf("to_wait%0d", k), {2'd2, 4'b0000, 4'b0110});
        end
        step(4'b0000, 3'b000);
        chk("to_fire", {2'd2, 4'b0000, 4'b0001});
        step(4'b1001, 3'b000);
        chk("to_ptr", {2'd3, 4'b1000, 4'b1011});
        step(4'b0000, 3'b110);
        chk("to_resp2", {2'd3, 4'b0000, 4'b0111});
        step(4'b0000, 3'b001);
        chk("to_idle2", {2'd3, 4'b0000, 4'b0001});

        // Asynchronous reset while in DATA with grant 2
        step(4'b0100, 3'b000);
        chk("rs_addr", {2'd2, 4'b0100, 4'b1011});
        step(4'b0000, 3'b100);
        chk("rs_data", {2'd2, 4'b0000, 4'b1011});
        @(negedge aclk);
        #1 rst = 1'b1;
        #1 chk("rs_async", 10'b0);
        @(negedge aclk);
        rst = 1'b0;
        step(4'b1111, 3'b000);
        chk("rs_regrant", {2'd0, 4'b0001, 4'b1010});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
